serial_adder4bit: RTL and testbench

Bit-serial ripple adder: the sequential, addition-direction counterpart of the 4-bit borrow subtractor. It latches two WIDTH-bit operands and a carry-in on a start pulse, then adds one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It returns the sum and carry-out with a one-cycle done pulse. It sits beside the subtractor in the arithmetic datapath, where area matters more than latency.

---
 rtl/arith_pkg.sv | 17 +
 rtl/full_adder_bit.sv | 15 +
 rtl/serial_adder4bit.sv | 92 +++++++++
 tb/tb_serial_adder4bit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: sequencing states, default width and
// the bit-level carry function used by the serial adder.
package arith_pkg;

  localparam int ADDER_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic majority3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single full-adder cell; the serial adder pushes every operand bit through it.
module full_adder_bit
  import arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = majority3(a, b, cin);

endmodule

// File: rtl/serial_adder4bit.sv
// Bit-serial adder: latches a, b, cin on start, adds one bit per clock LSB first,
// then presents sum/cout with a one-cycle done pulse.
module serial_adder4bit
  import arith_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c;

  full_adder_bit u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // r_acc is kept apart from r_sum so partial results never reach the port.
          r_acc   <= {w_s, r_acc[WIDTH-1:1]};
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_carry <= w_c;
          if (r_cnt == LAST_STEP) begin
            r_sum   <= {w_s, r_acc[WIDTH-1:1]};
            r_cout  <= w_c;
            r_state <= ST_DONE;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder4bit.sv
// Self-checking bench for serial_adder4bit: WIDTH=4 and WIDTH=8 instances checked
// against plain integer addition.
module tb_serial_adder4bit;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic [7:0] prev4, prev8;
  logic       prevc4, prevc8;
  int         n_checks = 0;
  int         n_fails  = 0;

  always #5 clk = ~clk;

  serial_adder4bit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_adder4bit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction
  function automatic logic get_cout(input int w);
    return (w == 4) ? cout4 : cout8;
  endfunction
  function automatic logic [7:0] get_sum(input int w);
    return (w == 4) ? {4'h0, sum4} : sum8;
  endfunction

  task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
    if (w == 4) begin
      start4 = st; a4 = a[3:0]; b4 = b[3:0]; cin4 = c;
    end else begin
      start8 = st; a8 = a; b8 = b; cin8 = c;
    end
  endtask

  // One complete operation; poke re-pulses start with junk operands mid-run.
  task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input bit poke);
    logic [8:0] full;
    logic [7:0] mask;
    logic [7:0] prev;
    logic [7:0] exp_sum;
    logic       exp_cout;
    int         cnt;
    mask     = (w == 4) ? 8'h0F : 8'hFF;
    full     = {1'b0, a & mask} + {1'b0, b & mask} + {8'd0, c};
    exp_sum  = full[7:0] & mask;
    exp_cout = (w == 4) ? full[4] : full[8];
    prev     = (w == 4) ? prev4 : prev8;

    drive(w, 1'b1, a, b, c);
    @(negedge clk);
    drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    check("busy_after_start", 32'(get_busy(w)), 32'd1);
    cnt = 0;
    while (get_done(w) !== 1'b1 && cnt < w + 3) begin
      if (poke && cnt == 1) drive(w, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      else if (poke && cnt == 2) drive(w, 1'b0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      cnt++;
      if (get_done(w) !== 1'b1) check("sum_hold_run", 32'(get_sum(w)), 32'(prev));
    end
    check("latency", 32'(cnt), 32'(w));
    check("sum", 32'(get_sum(w)), 32'(exp_sum));
    check("cout", 32'(get_cout(w)), 32'(exp_cout));
    check("busy_in_done", 32'(get_busy(w)), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(get_done(w)), 32'd0);
    check("busy_idle", 32'(get_busy(w)), 32'd0);
    check("sum_hold_idle", 32'(get_sum(w)), 32'(exp_sum));
    if (w == 4) begin prev4 = exp_sum; prevc4 = exp_cout; end
    else        begin prev8 = exp_sum; prevc8 = exp_cout; end
  endtask

  initial begin
    int  cnt;
    bit  seen;
    rst_n = 1'b0;
    drive(4, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    prev4 = 8'h00; prev8 = 8'h00; prevc4 = 1'b0; prevc8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_sum4",  32'(sum4),  32'd0);
    check("rst_cout4", 32'(cout4), 32'd0);
    check("rst_sum8",  32'(sum8),  32'd0);
    check("rst_cout8", 32'(cout8), 32'd0);

    // Directed cases.
    do_op(4, 8'h0, 8'h0, 1'b0, 1'b0);
    do_op(4, 8'h1, 8'h2, 1'b1, 1'b0);
    do_op(4, 8'hC, 8'hE, 1'b0, 1'b0);

    // Back-to-back: start held high, second operation taken in DONE.
    drive(4, 1'b1, 8'hF, 8'hF, 1'b1);
    @(negedge clk);
    cnt = 0;
    while (done4 !== 1'b1 && cnt < 8) begin @(negedge clk); cnt++; end
    check("b2b_latency1", 32'(cnt), 32'd4);
    check("b2b_sum1", 32'(sum4), 32'hF);
    check("b2b_cout1", 32'(cout4), 32'd1);
    drive(4, 1'b1, 8'h3, 8'h0, 1'b1);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (done4 !== 1'b1 && cnt < 10);
    drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    check("b2b_spacing", 32'(cnt), 32'd5);
    check("b2b_sum2", 32'(sum4), 32'h4);
    check("b2b_cout2", 32'(cout4), 32'd0);
    @(negedge clk);
    prev4 = 8'h4; prevc4 = 1'b0;

    // start pulsed during RUN is ignored.
    do_op(4, 8'h7, 8'h5, 1'b1, 1'b1);

    // Reset mid-run aborts; start at the reset edge is ignored.
    drive(4, 1'b1, 8'h9, 8'h9, 1'b0);
    @(negedge clk);
    drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(4, 1'b1, 8'h6, 8'h6, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_sum", 32'(sum4), 32'd0);
    check("abort_cout", 32'(cout4), 32'd0);
    check("abort_sum8", 32'(sum8), 32'd0);
    seen = 1'b0;
    repeat (7) begin
      if (done4 === 1'b1 || busy4 === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", 32'(seen), 32'd0);
    prev4 = 8'h0; prevc4 = 1'b0; prev8 = 8'h0; prevc8 = 1'b0;

    // WIDTH=8 boundary and random cases.
    do_op(8, 8'hFF, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      do_op(4, 8'($urandom), 8'($urandom), 1'($urandom), (i % 5) == 0);
    for (int i = 0; i < 10; i++)
      do_op(8, 8'($urandom), 8'($urandom), 1'($urandom), (i % 3) == 0);
    do_op(8, 8'hFF, 8'hFF, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
